vram_slot_arbiter: RTL and testbench

- Time-slot arbiter that shares one single-port video RAM among the tilemap fetcher, the sprite fetcher and the CPU.
- Slot ownership is derived from the video timing generator outputs (ce_pix, hb, vb, hcount). Each ce_pix pulse opens one RAM access slot.
- Sits between the timing generator, the two video fetch engines and the CPU bus. Display fetches get fixed, deterministic bandwidth; the CPU waits on a req/ack handshake.

---
 rtl/vram_slot_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: time-slot arbiter sharing one single-port VRAM among the
// tilemap fetcher, the sprite fetcher and the CPU. Each ce_pix pulse opens one
// access slot. The owner of the slot follows from vb/hb/hcount[0]. An access runs
// IDLE -> ISSUE -> CAPTURE -> DONE, so valid/ack arrives three cycles after ce_pix.
// Optional feature: define VRAM_SLOT_DONATE_EN to hand unused tile/sprite slots
// to a waiting CPU request.
module vram_slot_arbiter #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          hb,
    input  logic          vb,
    input  logic [8:0]    hcount,
    input  logic          tile_req,
    input  logic [AW-1:0] tile_addr,
    output logic [DW-1:0] tile_data,
    output logic          tile_valid,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_addr,
    output logic [DW-1:0] spr_data,
    output logic          spr_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {OWN_TILE, OWN_SPR, OWN_CPU} owner_t;

    state_t        state_q, state_d;
    owner_t        own_q, own_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] tile_data_q, tile_data_d;
    logic [DW-1:0] spr_data_q, spr_data_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;

    owner_t        slot_owner;
    owner_t        grant_owner;
    logic          grant;

    // Decide who owns the slot opening now and whether that owner takes it.
    always_comb begin
        slot_owner = OWN_CPU;
        if (!vb && !hcount[0]) begin
            slot_owner = hb ? OWN_SPR : OWN_TILE;
        end
        grant_owner = slot_owner;
        unique case (slot_owner)
            OWN_TILE: grant = tile_req;
            OWN_SPR:  grant = spr_req;
            default:  grant = cpu_req;
        endcase
`ifdef VRAM_SLOT_DONATE_EN
        // An idle display slot goes to the CPU when it is waiting.
        if (slot_owner != OWN_CPU && !grant && cpu_req) begin
            grant_owner = OWN_CPU;
            grant       = 1'b1;
        end
`endif
    end

    // Slot FSM next state, request latching, RAM strobes and completion pulses.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        addr_d      = addr_q;
        we_d        = we_q;
        din_d       = din_q;
        tile_data_d = tile_data_q;
        spr_data_d  = spr_data_q;
        cpu_dout_d  = cpu_dout_q;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        tile_valid  = 1'b0;
        spr_valid   = 1'b0;
        cpu_ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Request fields are frozen here; later changes cannot disturb the access.
                if (ce_pix && grant) begin
                    state_d = ISSUE;
                    own_d   = grant_owner;
                    din_d   = cpu_din;
                    we_d    = (grant_owner == OWN_CPU) && cpu_we;
                    unique case (grant_owner)
                        OWN_TILE: addr_d = tile_addr;
                        OWN_SPR:  addr_d = spr_addr;
                        default:  addr_d = cpu_addr;
                    endcase
                end
            end
            ISSUE: begin
                ram_cs   = 1'b1;
                ram_we   = we_q;
                ram_addr = addr_q;
                ram_din  = we_q ? din_q : '0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                // RAM read data is valid now, one cycle after the strobe.
                if (!we_q) begin
                    unique case (own_q)
                        OWN_TILE: tile_data_d = ram_dout;
                        OWN_SPR:  spr_data_d  = ram_dout;
                        default:  cpu_dout_d  = ram_dout;
                    endcase
                end
                state_d = DONE;
            end
            default: begin
                tile_valid = (own_q == OWN_TILE);
                spr_valid  = (own_q == OWN_SPR);
                cpu_ack    = (own_q == OWN_CPU);
                state_d    = IDLE;
            end
        endcase
    end

    // State and data registers; reset abandons any access in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            own_q       <= OWN_TILE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            tile_data_q <= '0;
            spr_data_q  <= '0;
            cpu_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            din_q       <= din_d;
            tile_data_q <= tile_data_d;
            spr_data_q  <= spr_data_d;
            cpu_dout_q  <= cpu_dout_d;
        end
    end

    assign tile_data = tile_data_q;
    assign spr_data  = spr_data_q;
    assign cpu_dout  = cpu_dout_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: behavioural slot model plus RAM model, per-cycle
// comparison of every output, and directed scenarios with literal expectations.
module tb_vram_slot_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_pix, hb, vb;
    logic [8:0]  hcount;
    logic        tile_req, spr_req, cpu_req, cpu_we;
    logic [12:0] tile_addr, spr_addr, cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  tile_data, spr_data, cpu_dout;
    logic        tile_valid, spr_valid, cpu_ack;
    logic        ram_cs, ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;

    vram_slot_arbiter dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hb(hb), .vb(vb),
        .hcount(hcount), .tile_req(tile_req), .tile_addr(tile_addr),
        .tile_data(tile_data), .tile_valid(tile_valid), .spr_req(spr_req),
        .spr_addr(spr_addr), .spr_data(spr_data), .spr_valid(spr_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Fixed initial RAM contents as a function of address
    function automatic logic [7:0] initv(input logic [12:0] a);
        case (a)
            13'h0123: return 8'h5A;
            13'h0040: return 8'h77;
            13'h0800: return 8'h3C;
            default:  return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Bench RAM: synchronous read, data one cycle after ram_cs
    logic       rw [0:8191];
    logic [7:0] rv [0:8191];
    always @(posedge clk_sys) begin
        if (ram_cs) begin
            ram_dout <= rw[ram_addr] ? rv[ram_addr] : initv(ram_addr);
            if (ram_we) begin
                rw[ram_addr] <= 1'b1;
                rv[ram_addr] <= ram_din;
            end
        end
    end

    // Behavioural model: age = cycles since slot start (-1 when free)
    int          age = -1;
    int          m_own = 0;           // 0 tile, 1 sprite, 2 cpu
    logic [12:0] m_addr = '0;
    logic        m_we = 1'b0;
    logic [7:0]  m_din = '0;
    logic [7:0]  e_td = '0, e_sd = '0, e_cd = '0;
    logic        mw [0:8191];
    logic [7:0]  mv [0:8191];

    always @(posedge clk_sys) begin
        int  o;
        logic rq;
        if (reset) begin
            age  = -1;
            e_td = '0; e_sd = '0; e_cd = '0;
        end else if (age >= 0) begin
            if (age == 1 && m_we) begin
                mw[m_addr] = 1'b1;
                mv[m_addr] = m_din;
            end
            if (age == 2 && !m_we) begin
                if (m_own == 0) e_td = mw[m_addr] ? mv[m_addr] : initv(m_addr);
                if (m_own == 1) e_sd = mw[m_addr] ? mv[m_addr] : initv(m_addr);
                if (m_own == 2) e_cd = mw[m_addr] ? mv[m_addr] : initv(m_addr);
            end
            age = age + 1;
            if (age == 4) age = -1;
        end else if (ce_pix) begin
            if (vb || hcount[0]) o = 2;
            else o = hb ? 1 : 0;
            rq = (o == 0) ? tile_req : (o == 1) ? spr_req : cpu_req;
`ifdef VRAM_SLOT_DONATE_EN
            if (o != 2 && !rq && cpu_req) begin
                o  = 2;
                rq = 1'b1;
            end
`endif
            if (rq) begin
                m_own  = o;
                m_addr = (o == 0) ? tile_addr : (o == 1) ? spr_addr : cpu_addr;
                m_we   = (o == 2) && cpu_we;
                m_din  = cpu_din;
                age    = 1;
            end
        end
    end

    int n_chk = 0, n_pass = 0;
    int cyc = 0, ce_cyc = 0;
    int cnt_cs = 0, cnt_tv = 0, cnt_sv = 0, cnt_ack = 0;
    int s_cs, s_tv, s_sv, s_ack;
    int lat_tile = -1, lat_spr = -1, lat_cpu = -1;
    logic [12:0] last_addr = '0;
    logic        last_we = 1'b0;
    logic [7:0]  last_din = '0;
    logic        armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: advance, then compare all outputs against the model and log events
    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
        if (armed) begin
            chk("ram_cs",     ram_cs,     age == 1);
            chk("ram_we",     ram_we,     age == 1 && m_we);
            chk("ram_addr",   ram_addr,   (age == 1) ? m_addr : 13'h0);
            chk("ram_din",    ram_din,    (age == 1 && m_we) ? m_din : 8'h0);
            chk("tile_valid", tile_valid, age == 3 && m_own == 0);
            chk("spr_valid",  spr_valid,  age == 3 && m_own == 1);
            chk("cpu_ack",    cpu_ack,    age == 3 && m_own == 2);
            chk("tile_data",  tile_data,  e_td);
            chk("spr_data",   spr_data,   e_sd);
            chk("cpu_dout",   cpu_dout,   e_cd);
        end
        if (ram_cs) begin
            cnt_cs++;
            last_addr = ram_addr; last_we = ram_we; last_din = ram_din;
        end
        if (tile_valid) begin cnt_tv++;  lat_tile = cyc - ce_cyc; end
        if (spr_valid)  begin cnt_sv++;  lat_spr  = cyc - ce_cyc; end
        if (cpu_ack)    begin cnt_ack++; lat_cpu  = cyc - ce_cyc; end
    endtask

    task automatic snap();
        s_cs = cnt_cs; s_tv = cnt_tv; s_sv = cnt_sv; s_ack = cnt_ack;
    endtask

    // One 8-cycle ce_pix period; the current cycle is slot start T
    task automatic slot(input logic v, input logic h, input logic [8:0] hc);
        vb = v; hb = h; hcount = hc; ce_pix = 1'b1; ce_cyc = cyc;
        step();
        ce_pix = 1'b0;
        repeat (7) step();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            rw[i] = 1'b0; mw[i] = 1'b0;
        end
        reset = 1'b1; ce_pix = 1'b0; hb = 1'b0; vb = 1'b0; hcount = '0;
        tile_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        tile_addr = '0; spr_addr = '0; cpu_addr = '0; cpu_din = '0;
        repeat (3) step();
        armed = 1'b1;
        reset = 1'b0;
        step();
        chk("rst_tile_data", tile_data, 8'h00);
        chk("rst_cpu_ack", cpu_ack, 1'b0);

        // Tile read; address change after T must not matter
        snap();
        tile_req = 1'b1; tile_addr = 13'h0123;
        vb = 1'b0; hb = 1'b0; hcount = 9'd10; ce_pix = 1'b1; ce_cyc = cyc;
        step();
        ce_pix = 1'b0; tile_addr = 13'h0999;
        repeat (7) step();
        chk("t1_cs_count", cnt_cs - s_cs, 1);
        chk("t1_addr", last_addr, 13'h0123);
        chk("t1_valid_count", cnt_tv - s_tv, 1);
        chk("t1_latency", lat_tile, 3);
        chk("t1_data", tile_data, 8'h5A);
        chk("t1_no_ack", cnt_ack - s_ack, 0);

        // CPU write waits for its own odd slot
        snap();
        tile_addr = 13'h0124;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_din = 8'hC3;
        slot(1'b0, 1'b0, 9'd10);
        chk("t2_no_ack_even", cnt_ack - s_ack, 0);
        chk("t2_even_we", last_we, 1'b0);
        chk("t2_even_addr", last_addr, 13'h0124);
        snap();
        tile_req = 1'b0;
        slot(1'b0, 1'b0, 9'd11);
        chk("t2_ack_count", cnt_ack - s_ack, 1);
        chk("t2_we", last_we, 1'b1);
        chk("t2_din", last_din, 8'hC3);
        chk("t2_addr", last_addr, 13'h1FFF);
        chk("t2_latency", lat_cpu, 3);
        chk("t2_dout_kept", cpu_dout, 8'h00);
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Vertical blank: CPU owns even slot too, sprite ignored
        snap();
        spr_req = 1'b1; spr_addr = 13'h0200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
        slot(1'b1, 1'b0, 9'd20);
        chk("t3_dout", cpu_dout, 8'h77);
        chk("t3_no_spr", cnt_sv - s_sv, 0);
        chk("t3_ack", cnt_ack - s_ack, 1);
        cpu_req = 1'b0;

        // Horizontal blank: sprite on even, CPU on odd
        snap();
        spr_addr = 13'h0800;
        slot(1'b0, 1'b1, 9'd300);
        chk("t4_spr_count", cnt_sv - s_sv, 1);
        chk("t4_spr_data", spr_data, 8'h3C);
        chk("t4_spr_latency", lat_spr, 3);
        chk("t4_cs_even", cnt_cs - s_cs, 1);
        spr_req = 1'b0;
        snap();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
        slot(1'b0, 1'b1, 9'd301);
        chk("t4_cpu_ack", cnt_ack - s_ack, 1);
        chk("t4_cs_odd", cnt_cs - s_cs, 1);
        chk("t4_readback", cpu_dout, 8'hC3);
        cpu_req = 1'b0;

        // Reset during CAPTURE of a tile read
        snap();
        tile_req = 1'b1; tile_addr = 13'h0123;
        vb = 1'b0; hb = 1'b0; hcount = 9'd12; ce_pix = 1'b1; ce_cyc = cyc;
        step();
        ce_pix = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_tile_data_zero", tile_data, 8'h00);
        chk("t5_spr_data_zero", spr_data, 8'h00);
        chk("t5_cpu_dout_zero", cpu_dout, 8'h00);
        repeat (5) step();
        chk("t5_no_valid", cnt_tv - s_tv, 0);
        snap();
        slot(1'b0, 1'b0, 9'd14);
        chk("t5_after_valid", cnt_tv - s_tv, 1);
        chk("t5_after_data", tile_data, 8'h5A);

        // Unused tile slot with CPU waiting
        snap();
        tile_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
        slot(1'b0, 1'b0, 9'd10);
`ifdef VRAM_SLOT_DONATE_EN
        chk("t6_donated_ack", cnt_ack - s_ack, 1);
        chk("t6_donated_cs", cnt_cs - s_cs, 1);
        chk("t6_donated_dout", cpu_dout, 8'h77);
        chk("t6_donated_latency", lat_cpu, 3);
`else
        chk("t6_idle_ack", cnt_ack - s_ack, 0);
        chk("t6_idle_cs", cnt_cs - s_cs, 0);
        snap();
        slot(1'b0, 1'b0, 9'd11);
        chk("t6_odd_ack", cnt_ack - s_ack, 1);
        chk("t6_odd_dout", cpu_dout, 8'h77);
`endif
        cpu_req = 1'b0;

        // ce_pix too close to the previous one is ignored
        snap();
        tile_req = 1'b1; tile_addr = 13'h0800;
        vb = 1'b0; hb = 1'b0; hcount = 9'd14; ce_pix = 1'b1; ce_cyc = cyc;
        step();
        ce_pix = 1'b0;
        step();
        hcount = 9'd16; ce_pix = 1'b1;
        step();
        ce_pix = 1'b0;
        repeat (6) step();
        chk("t7_one_cs", cnt_cs - s_cs, 1);
        chk("t7_one_valid", cnt_tv - s_tv, 1);
        chk("t7_data", tile_data, 8'h3C);
        tile_req = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
